// File: rtl/dec_sync_ctrl_if.sv
// Raw-word, aligned-symbol and status bundle for dec_sync_ctrl.
// The master side is the receive front end; the slave side is the controller.
interface dec_sync_ctrl_if;
    logic        raw_valid;
    logic [9:0]  raw_in;
    logic        err_in;
    logic        aligned_valid;
    logic [9:0]  aligned_word;
    logic [3:0]  offset;
    logic        sync_ok;
    logic        rd_load;
    logic        rd_seed;
    logic        stat_clr;
    logic [15:0] los_count;
    logic [15:0] err_count;

    modport master (
        output raw_valid, raw_in, err_in, stat_clr,
        input  aligned_valid, aligned_word, offset, sync_ok, rd_load, rd_seed,
        input  los_count, err_count
    );

    modport slave (
        input  raw_valid, raw_in, err_in, stat_clr,
        output aligned_valid, aligned_word, offset, sync_ok, rd_load, rd_seed,
        output los_count, err_count
    );
endinterface

// File: rtl/dec_sync_ctrl.sv
// Comma search over all 10 bit offsets, symbol alignment and hunt/verify/sync control.
// Define DEC_SYNC_STATS_EN to build the loss-of-sync and errored-symbol counters.
module dec_sync_ctrl #(
    parameter int unsigned COMMA_NEED   = 3,
    parameter int unsigned ERR_MAX      = 4,
    parameter int unsigned GOOD_RECOVER = 4
) (
    input logic            clk,
    input logic            reset,
    dec_sync_ctrl_if.slave bus
);
    localparam logic [1:0] StHunt   = 2'd0;
    localparam logic [1:0] StVerify = 2'd1;
    localparam logic [1:0] StSync   = 2'd2;

    localparam logic [3:0] CommaNeed   = 4'(COMMA_NEED);
    localparam logic [3:0] ErrMax      = 4'(ERR_MAX);
    localparam logic [3:0] GoodRecover = 4'(GOOD_RECOVER);
    localparam logic [6:0] CommaNeg    = 7'b0011111;
    localparam logic [6:0] CommaPos    = 7'b1100000;

    logic [1:0]  state_q, state_d, state_m;
    logic [9:0]  prev_raw_q;
    logic [3:0]  offset_q, offset_d;
    logic [3:0]  comma_cnt_q, comma_cnt_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic        av_q;
    logic [9:0]  word_q, word_d;
    logic        seed_q, seed_d;
    logic        rd_load_q, rd_load_d;
    logic        chk_verify_q, chk_verify_d;
    logic        chk_sync_q, chk_sync_d;
    logic        los_evt, err_evt;

    logic [19:0] win;
    logic [9:0]  cand [10];
    logic [9:0]  comma_hit;
    logic        any_hit;
    logic [3:0]  first_k;

    always_comb begin
        win       = {prev_raw_q, bus.raw_in};
        comma_hit = '0;
        for (int k = 0; k < 10; k++) begin
            cand[k]      = win[19-k -: 10];
            comma_hit[k] = (cand[k][9:3] == CommaNeg) || (cand[k][9:3] == CommaPos);
        end
        first_k = '0;
        for (int k = 9; k >= 0; k--) begin
            if (comma_hit[k]) first_k = 4'(k);
        end
        any_hit = |comma_hit;
    end

    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        comma_cnt_d  = comma_cnt_q;
        err_cnt_d    = err_cnt_q;
        good_cnt_d   = good_cnt_q;
        word_d       = word_q;
        seed_d       = seed_q;
        rd_load_d    = 1'b0;
        chk_verify_d = 1'b0;
        chk_sync_d   = 1'b0;
        los_evt      = 1'b0;
        err_evt      = 1'b0;

        // err_in belongs to last cycle's aligned word, so settle that word before the new one.
        if (av_q && chk_verify_q && bus.err_in) begin
            state_d     = StHunt;
            comma_cnt_d = '0;
        end else if (av_q && chk_sync_q) begin
            if (bus.err_in) begin
                err_evt    = 1'b1;
                good_cnt_d = '0;
                err_cnt_d  = (err_cnt_q == 4'hF) ? err_cnt_q : err_cnt_q + 4'd1;
                if (err_cnt_d >= ErrMax) begin
                    state_d   = StHunt;
                    err_cnt_d = '0;
                    los_evt   = 1'b1;
                end
            end else if (good_cnt_q + 4'd1 >= GoodRecover) begin
                good_cnt_d = '0;
                if (err_cnt_q != '0) err_cnt_d = err_cnt_q - 4'd1;
            end else begin
                good_cnt_d = good_cnt_q + 4'd1;
            end
        end

        state_m = state_d;
        if (bus.raw_valid) begin
            case (state_m)
                StHunt: begin
                    if (any_hit) begin
                        offset_d    = first_k;
                        comma_cnt_d = 4'd1;
                        state_d     = StVerify;
                    end
                end
                StVerify: begin
                    if (comma_hit[offset_d]) begin
                        if (comma_cnt_d != 4'hF) comma_cnt_d = comma_cnt_d + 4'd1;
                        if (comma_cnt_d >= CommaNeed) begin
                            state_d     = StSync;
                            comma_cnt_d = '0;
                            rd_load_d   = 1'b1;
                        end
                    end else if (any_hit) begin
                        offset_d    = first_k;
                        comma_cnt_d = 4'd1;
                    end
                end
                default: ;
            endcase
            word_d = cand[offset_d];
            if (comma_hit[offset_d]) seed_d = (cand[offset_d][9:3] == CommaNeg);
            chk_verify_d = (state_m == StVerify) && !comma_hit[offset_d];
            chk_sync_d   = (state_m == StSync);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StHunt;
            prev_raw_q   <= '0;
            offset_q     <= '0;
            comma_cnt_q  <= '0;
            err_cnt_q    <= '0;
            good_cnt_q   <= '0;
            av_q         <= 1'b0;
            word_q       <= '0;
            seed_q       <= 1'b0;
            rd_load_q    <= 1'b0;
            chk_verify_q <= 1'b0;
            chk_sync_q   <= 1'b0;
        end else begin
            if (bus.raw_valid) prev_raw_q <= bus.raw_in;
            state_q      <= state_d;
            offset_q     <= offset_d;
            comma_cnt_q  <= comma_cnt_d;
            err_cnt_q    <= err_cnt_d;
            good_cnt_q   <= good_cnt_d;
            av_q         <= bus.raw_valid;
            word_q       <= word_d;
            seed_q       <= seed_d;
            rd_load_q    <= rd_load_d;
            chk_verify_q <= chk_verify_d;
            chk_sync_q   <= chk_sync_d;
        end
    end

    assign bus.aligned_valid = av_q;
    assign bus.aligned_word  = word_q;
    assign bus.offset        = offset_q;
    assign bus.sync_ok       = (state_q == StSync);
    assign bus.rd_load       = rd_load_q;
    assign bus.rd_seed       = seed_q;

`ifdef DEC_SYNC_STATS_EN
    logic [15:0] los_count_q, err_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            los_count_q <= '0;
            err_count_q <= '0;
        end else if (bus.stat_clr) begin
            los_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if (los_evt && los_count_q != 16'hFFFF) los_count_q <= los_count_q + 16'd1;
            if (err_evt && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
        end
    end

    assign bus.los_count = los_count_q;
    assign bus.err_count = err_count_q;
`else
    logic unused_stat;
    assign unused_stat   = bus.stat_clr ^ los_evt ^ err_evt;
    assign bus.los_count = '0;
    assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_dec_sync_ctrl.sv
// Bench for dec_sync_ctrl: directed alignment/sync scenarios plus randomized bit streams,
// checked every cycle against a per-word reference model of the sync rules.
module tb_dec_sync_ctrl;
    localparam int CommaNeed   = 3;
    localparam int ErrMax      = 4;
    localparam int GoodRecover = 4;
    localparam int Hunt = 0, Verify = 1, Sync = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    dec_sync_ctrl_if bus ();

    dec_sync_ctrl #(
        .COMMA_NEED  (CommaNeed),
        .ERR_MAX     (ErrMax),
        .GOOD_RECOVER(GoodRecover)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int         m_state, m_off, m_cnt, m_ecnt, m_good, m_los, m_errw;
    logic [9:0] m_prev;
    logic       m_seed;
    logic       exp_av, exp_sync, exp_rdload;
    logic [9:0] exp_word;
    logic       pend_v, pend_err;

    bit bitq[$];
    bit errq[$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic is_comma(input logic [9:0] c);
        return (c[9:3] == 7'b0011111) || (c[9:3] == 7'b1100000);
    endfunction

    task automatic model_reset();
        m_state = Hunt; m_off = 0; m_cnt = 0; m_ecnt = 0; m_good = 0;
        m_los = 0; m_errw = 0; m_prev = '0; m_seed = 1'b0;
        exp_av = 1'b0; exp_sync = 1'b0; exp_rdload = 1'b0; exp_word = '0;
        pend_v = 1'b0; pend_err = 1'b0;
    endtask

    // One word, applied atomically with its own error flag.
    task automatic model_word(input logic [9:0] raw, input logic e);
        logic [19:0] w;
        logic [9:0]  cur;
        int          first;
        logic        exit_sync;
        w = {m_prev, raw};
        m_prev = raw;
        first = -1;
        for (int k = 9; k >= 0; k--) if (is_comma(10'(w >> (10 - k)))) first = k;
        exp_rdload = 1'b0;
        exit_sync  = 1'b0;
        case (m_state)
            Hunt: if (first >= 0) begin m_off = first; m_cnt = 1; m_state = Verify; end
            Verify: begin
                if (is_comma(10'(w >> (10 - m_off)))) begin
                    m_cnt++;
                    if (m_cnt == CommaNeed) begin m_state = Sync; exp_rdload = 1'b1; end
                end else if (first >= 0) begin
                    m_off = first; m_cnt = 1;
                end else if (e) begin
                    m_state = Hunt;
                end
            end
            default: begin
                if (e) begin
                    m_errw++; m_ecnt++; m_good = 0;
                    if (m_ecnt == ErrMax) begin
                        m_state = Hunt; m_ecnt = 0; m_los++; exit_sync = 1'b1;
                    end
                end else begin
                    m_good++;
                    if (m_good == GoodRecover) begin
                        m_good = 0;
                        if (m_ecnt > 0) m_ecnt--;
                    end
                end
            end
        endcase
        cur = 10'(w >> (10 - m_off));
        if (is_comma(cur)) m_seed = (cur[9:3] == 7'b0011111);
        exp_av   = 1'b1;
        exp_word = cur;
        // An error-driven exit from sync shows one clock later than the word itself.
        exp_sync = (m_state == Sync) || exit_sync;
    endtask

    task automatic compare_outputs();
        check("aligned_valid", 16'(bus.aligned_valid), 16'(exp_av));
        if (exp_av) check("aligned_word", 16'(bus.aligned_word), 16'(exp_word));
        check("offset", 16'(bus.offset), 16'(m_off));
        check("sync_ok", 16'(bus.sync_ok), 16'(exp_sync));
        check("rd_load", 16'(bus.rd_load), 16'(exp_rdload));
        check("rd_seed", 16'(bus.rd_seed), 16'(m_seed));
    endtask

    task automatic step(input logic v, input logic [9:0] raw, input logic e);
        @(negedge clk);
        compare_outputs();
        bus.err_in    = pend_v ? pend_err : 1'($urandom_range(1));
        bus.raw_valid = v;
        bus.raw_in    = v ? raw : 10'($urandom);
        pend_v   = v;
        pend_err = e;
        if (v) model_word(raw, e);
        else begin
            exp_av = 1'b0; exp_rdload = 1'b0; exp_sync = (m_state == Sync);
        end
    endtask

    task automatic check_stats(input string tag);
        logic [15:0] el, ee;
`ifdef DEC_SYNC_STATS_EN
        el = 16'(m_los); ee = 16'(m_errw);
`else
        el = '0; ee = '0;
`endif
        check({tag, "_los_count"}, bus.los_count, el);
        check({tag, "_err_count"}, bus.err_count, ee);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_av"}, 16'(bus.aligned_valid), 16'd0);
        check({tag, "_word"}, 16'(bus.aligned_word), 16'd0);
        check({tag, "_offset"}, 16'(bus.offset), 16'd0);
        check({tag, "_sync"}, 16'(bus.sync_ok), 16'd0);
        check({tag, "_rdload"}, 16'(bus.rd_load), 16'd0);
        check({tag, "_seed"}, 16'(bus.rd_seed), 16'd0);
        check({tag, "_los"}, bus.los_count, 16'd0);
        check({tag, "_errc"}, bus.err_count, 16'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        compare_outputs();
        bus.raw_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_zero(tag);
        model_reset();
        bitq.delete();
        errq.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push_sym(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) bitq.push_back(s[i]);
    endtask

    task automatic push_bits(input int n, input logic [9:0] pat);
        for (int i = n - 1; i >= 0; i--) bitq.push_back(pat[i]);
    endtask

    task automatic flush_words(input int err_pct, input int gap_pct);
        logic [9:0] w;
        logic       e;
        while (bitq.size() >= 10) begin
            for (int i = 9; i >= 0; i--) w[i] = bitq.pop_front();
            if (errq.size() > 0) e = errq.pop_front();
            else e = ($urandom_range(99) < err_pct);
            if ($urandom_range(99) < gap_pct) step(1'b0, '0, 1'b0);
            step(1'b1, w, e);
        end
    endtask

    initial begin
        int err_pct;
        bus.raw_valid = 1'b0;
        bus.raw_in    = '0;
        bus.err_in    = 1'b0;
        bus.stat_clr  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_zero("reset");
        reset = 1'b1;

        // K28.5 RD- stream aligned at offset 0
        repeat (5) push_sym(10'h0FA);
        flush_words(0, 0);
        step(1'b0, '0, 1'b0);
        check("t1_offset", 16'(bus.offset), 16'd0);
        check("t1_sync", 16'(bus.sync_ok), 16'd1);
        check("t1_seed", 16'(bus.rd_seed), 16'd1);

        // Same stream shifted by four bits
        do_reset("t2_rst");
        push_bits(4, 10'h000);
        repeat (5) push_sym(10'h0FA);
        flush_words(0, 0);
        step(1'b0, '0, 1'b0);
        check("t2_offset", 16'(bus.offset), 16'd4);
        check("t2_sync", 16'(bus.sync_ok), 16'd1);

        // Lock at offset 2, then the comma moves to offset 7 during verify
        do_reset("t3_rst");
        push_bits(2, 10'h000);
        repeat (2) push_sym(10'h0FA);
        push_bits(5, 10'h015);
        push_sym(10'h0FA);
        flush_words(0, 0);
        step(1'b0, '0, 1'b0);
        check("t3_relatch_sync", 16'(bus.sync_ok), 16'd0);
        repeat (4) push_sym(10'h0FA);
        flush_words(0, 0);
        step(1'b0, '0, 1'b0);
        check("t3_offset", 16'(bus.offset), 16'd7);
        check("t3_sync", 16'(bus.sync_ok), 16'd1);

        // Four consecutive errored words in sync drop the link
        repeat (4) errq.push_back(1'b1);
        repeat (6) push_sym(10'h2AA);
        flush_words(0, 0);
        repeat (2) step(1'b0, '0, 1'b0);
        check("t4_sync", 16'(bus.sync_ok), 16'd0);
`ifdef DEC_SYNC_STATS_EN
        check("t4_los", bus.los_count, 16'd1);
        check("t4_errc", bus.err_count, 16'd4);
`endif
        check_stats("t4");

        // Sparse errors are forgiven; a burst of four is not
        do_reset("t5_rst");
        repeat (5) push_sym(10'h0FA);
        flush_words(0, 0);
        repeat (3) begin
            errq.push_back(1'b1);
            repeat (4) errq.push_back(1'b0);
        end
        repeat (15) push_sym(10'h2AA);
        flush_words(0, 0);
        step(1'b0, '0, 1'b0);
        check("t5_sparse_sync", 16'(bus.sync_ok), 16'd1);
        repeat (4) errq.push_back(1'b1);
        repeat (5) push_sym(10'h2AA);
        flush_words(0, 0);
        step(1'b0, '0, 1'b0);
        check("t5_burst_sync", 16'(bus.sync_ok), 16'd0);

        // Gaps hold verify; reset in verify clears everything
        do_reset("t6_rst");
        repeat (3) push_sym(10'h0FA);
        flush_words(0, 50);
        repeat (3) step(1'b0, '0, 1'b0);
        check("t6_gap_sync", 16'(bus.sync_ok), 16'd0);
        do_reset("t6_verify_rst");
        repeat (5) push_sym(10'h0FA);
        flush_words(0, 30);

        // Randomized streams
        for (int ep = 0; ep < 40; ep++) begin
            if ($urandom_range(3) == 0) do_reset("rnd_rst");
            case ($urandom_range(2))
                0:       err_pct = 0;
                1:       err_pct = 4;
                default: err_pct = 25;
            endcase
            push_bits($urandom_range(9), 10'($urandom));
            for (int s = 0; s < 30; s++) begin
                if ($urandom_range(99) < 35) push_sym($urandom_range(1) ? 10'h0FA : 10'h305);
                else push_sym(10'($urandom));
            end
            flush_words(err_pct, 15);
        end
        repeat (3) step(1'b0, '0, 1'b0);
        check_stats("end");

        bus.stat_clr = 1'b1;
        step(1'b0, '0, 1'b0);
        bus.stat_clr = 1'b0;
        m_los  = 0;
        m_errw = 0;
        step(1'b0, '0, 1'b0);
        check_stats("clr");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
